// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the 5-stage pipeline.
// Commits GPR writes, updates HI/LO, holds CP0 Status/Cause/EPC and resolves
// SYSCALL/BREAK/ERET (and optionally the timer interrupt) into a fetch
// redirect plus an upstream flush.
// Optional feature macro: CP0_COUNT_EN (adds CP0 Count/Compare and the IP7
// timer interrupt). With it undefined the build has no timer and no interrupt.
module wb_stage #(
  parameter logic [31:0] EXC_ENTER_ADDR = 32'h0000_0000,
  parameter logic [31:0] STATUS_RESET   = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         WB_valid,
  input  logic [118:0] MEM_WB_bus_r,
  output logic         rf_wen,
  output logic [4:0]   rf_wdest,
  output logic [31:0]  rf_wdata,
  output logic         WB_over,
  output logic [4:0]   WB_wdest,
  output logic         exc_valid,
  output logic [31:0]  exc_pc,
  output logic         cancel,
  output logic [31:0]  WB_pc,
  output logic [31:0]  HI_data,
  output logic [31:0]  LO_data
);

  // Bus layout from MEM, MSB first.
  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
    logic        brk;
  } mem_wb_bus_t;

  localparam logic [7:0]  ADDR_COUNT   = 8'h48;
  localparam logic [7:0]  ADDR_COMPARE = 8'h58;
  localparam logic [7:0]  ADDR_STATUS  = 8'h60;
  localparam logic [7:0]  ADDR_CAUSE   = 8'h68;
  localparam logic [7:0]  ADDR_EPC     = 8'h70;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;  // IM[15:8], EXL, IE

  mem_wb_bus_t bus;
  assign bus = mem_wb_bus_t'(MEM_WB_bus_r);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic        int_take, take_exc, take_eret, do_mtc0;
  logic [31:0] cp0_rdata;

`ifdef CP0_COUNT_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        toggle_q, toggle_d;
  assign int_take = WB_valid & status_q[0] & status_q[15] & ~status_q[1] & cause_q[15];
`else
  assign int_take = 1'b0;
`endif

  // Event resolution in priority order: interrupt, syscall/break, eret, mtc0.
  assign take_exc  = WB_valid & ~int_take & (bus.syscall | bus.brk);
  assign take_eret = WB_valid & ~int_take & ~(bus.syscall | bus.brk) & bus.eret;
  assign do_mtc0   = WB_valid & ~int_take & ~(bus.syscall | bus.brk) & ~bus.eret & bus.mtc0;

  // CP0 read mux; unknown addresses read zero.
  always_comb begin
    cp0_rdata = 32'h0;
    unique case (bus.cp0r_addr)
      ADDR_STATUS:  cp0_rdata = status_q;
      ADDR_CAUSE:   cp0_rdata = cause_q;
      ADDR_EPC:     cp0_rdata = epc_q;
`ifdef CP0_COUNT_EN
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
`endif
      default:      cp0_rdata = 32'h0;
    endcase
  end

  // Combinational write-back outputs: zero added latency from the bus.
  always_comb begin
    rf_wen    = WB_valid & bus.rf_wen & ~bus.syscall & ~bus.brk & ~int_take;
    rf_wdest  = bus.rf_wdest;
    if (bus.mfhi)      rf_wdata = hi_q;
    else if (bus.mflo) rf_wdata = lo_q;
    else if (bus.mfc0) rf_wdata = cp0_rdata;
    else               rf_wdata = bus.mem_result;
    WB_over   = WB_valid;
    WB_wdest  = bus.rf_wdest & {5{WB_valid}};
    exc_valid = int_take | take_exc | take_eret;
    exc_pc    = take_eret ? epc_q : EXC_ENTER_ADDR;
    cancel    = exc_valid & WB_over;
    WB_pc     = bus.pc;
    HI_data   = hi_q;
    LO_data   = lo_q;
  end

  // Next-state for HI/LO and CP0.
  // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
`ifdef CP0_COUNT_EN
    toggle_d  = ~toggle_q;
    count_d   = toggle_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    if (count_q == compare_q && compare_q != 32'h0) cause_d[15] = 1'b1;
`endif
    if (WB_valid && !int_take && bus.hi_write) hi_d = bus.mem_result;
    if (WB_valid && !int_take && bus.lo_write) lo_d = bus.lo_result;

    if (int_take) begin
      epc_d        = bus.pc;
      status_d[1]  = 1'b1;
      cause_d[6:2] = 5'd0;
    end else if (take_exc) begin
      epc_d        = bus.pc;
      status_d[1]  = 1'b1;
      cause_d[6:2] = bus.syscall ? 5'd8 : 5'd9;
    end else if (take_eret) begin
      status_d[1]  = 1'b0;
    end else if (do_mtc0) begin
      unique case (bus.cp0r_addr)
        ADDR_STATUS:  status_d     = bus.mem_result & STATUS_WMASK;
        ADDR_CAUSE:   cause_d[9:8] = bus.mem_result[9:8];
        ADDR_EPC:     epc_d        = bus.mem_result;
`ifdef CP0_COUNT_EN
        ADDR_COUNT:   count_d      = bus.mem_result;
        ADDR_COMPARE: begin
          compare_d   = bus.mem_result;
          cause_d[15] = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      status_q  <= STATUS_RESET;
      cause_q   <= 32'h0;
      epc_q     <= 32'h0;
`ifdef CP0_COUNT_EN
      count_q   <= 32'h0;
      compare_q <= 32'h0;
      toggle_q  <= 1'b0;
`endif
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
`ifdef CP0_COUNT_EN
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage. Inputs change on the falling
// edge and outputs are sampled 1 time unit later; state commits on the
// following rising edge.
module tb_wb_stage;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic [31:0] pc;
    logic        brk;
  } bus_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         WB_valid;
  logic [118:0] MEM_WB_bus_r;
  logic         rf_wen, WB_over, exc_valid, cancel;
  logic [4:0]   rf_wdest, WB_wdest;
  logic [31:0]  rf_wdata, exc_pc, WB_pc, HI_data, LO_data;

  int vectors = 0;
  int miscompares = 0;

  wb_stage dut (
    .clk(clk), .resetn(resetn), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
    .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_over(WB_over),
    .WB_wdest(WB_wdest), .exc_valid(exc_valid), .exc_pc(exc_pc), .cancel(cancel),
    .WB_pc(WB_pc), .HI_data(HI_data), .LO_data(LO_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply(input logic v, input bus_t b);
    WB_valid     = v;
    MEM_WB_bus_r = b;
  endtask

  task automatic step(input logic v, input bus_t b);
    @(negedge clk);
    apply(v, b);
    #1;
  endtask

  function automatic bus_t mk_alu(input logic [4:0] dest, input logic [31:0] data);
    bus_t b = '0;
    b.rf_wen = 1'b1; b.rf_wdest = dest; b.mem_result = data; b.pc = 32'h100;
    return b;
  endfunction

  function automatic bus_t mk_mfc0(input logic [7:0] addr);
    bus_t b = mk_alu(5'd4, 32'hdead_beef);
    b.mfc0 = 1'b1; b.cp0r_addr = addr;
    return b;
  endfunction

  function automatic bus_t mk_mtc0(input logic [7:0] addr, input logic [31:0] data);
    bus_t b = '0;
    b.mtc0 = 1'b1; b.cp0r_addr = addr; b.mem_result = data;
    return b;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_t b;
    resetn = 1'b0;
    apply(1'b0, '0);
    #1;
    check("reset_hi", HI_data, 32'h0);
    check("reset_lo", LO_data, 32'h0);
    check("reset_exc_valid", exc_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: ALU op.
    step(1'b1, mk_alu(5'd5, 32'h1234));
    check("alu_rf_wen", rf_wen, 1'b1);
    check("alu_rf_wdest", rf_wdest, 5'd5);
    check("alu_rf_wdata", rf_wdata, 32'h1234);
    check("alu_wb_wdest", WB_wdest, 5'd5);
    check("alu_exc_valid", exc_valid, 1'b0);
    check("alu_cancel", cancel, 1'b0);

    // 2: MULT writes HI/LO together, visible next cycle.
    b = '0; b.hi_write = 1'b1; b.lo_write = 1'b1; b.mem_result = 32'hA; b.lo_result = 32'hB;
    step(1'b1, b);
    check("mult_hi_before_edge", HI_data, 32'h0);
    b = mk_alu(5'd2, 32'h0); b.mfhi = 1'b1;
    step(1'b1, b);
    check("mfhi", rf_wdata, 32'hA);
    b = mk_alu(5'd2, 32'h0); b.mflo = 1'b1;
    step(1'b1, b);
    check("mflo", rf_wdata, 32'hB);
    // MFLO alongside an LO write reads the old value.
    b = mk_alu(5'd2, 32'h0); b.mflo = 1'b1; b.lo_write = 1'b1; b.lo_result = 32'hD;
    step(1'b1, b);
    check("mflo_old_value", rf_wdata, 32'hB);
    step(1'b0, '0);
    check("lo_updated", LO_data, 32'hD);
    check("hi_kept", HI_data, 32'hA);

    // 3: SYSCALL at pc 0x40.
    b = mk_alu(5'd3, 32'h55); b.syscall = 1'b1; b.pc = 32'h40;
    step(1'b1, b);
    check("sys_exc_valid", exc_valid, 1'b1);
    check("sys_exc_pc", exc_pc, 32'h0);
    check("sys_cancel", cancel, 1'b1);
    check("sys_rf_wen", rf_wen, 1'b0);
    check("sys_wb_pc", WB_pc, 32'h40);
    step(1'b1, mk_mfc0(8'h70));
    check("sys_epc", rf_wdata, 32'h40);
    step(1'b1, mk_mfc0(8'h68));
    check("sys_cause", rf_wdata, 32'h20);
    step(1'b1, mk_mfc0(8'h60));
    check("sys_status_exl", rf_wdata, 32'h2);

    // Invalid slot: nothing fires even with syscall on the bus.
    step(1'b0, b);
    check("bubble_exc_valid", exc_valid, 1'b0);
    check("bubble_cancel", cancel, 1'b0);
    check("bubble_wb_wdest", WB_wdest, 5'd0);

    // BREAK while EXL=1 still overwrites EPC.
    b = '0; b.brk = 1'b1; b.pc = 32'h48;
    step(1'b1, b);
    check("brk_exc_valid", exc_valid, 1'b1);
    step(1'b1, mk_mfc0(8'h68));
    check("brk_cause", rf_wdata, 32'h24);
    step(1'b1, mk_mfc0(8'h70));
    check("brk_epc_nested", rf_wdata, 32'h48);

    // MTC0 writable-bit masks and unknown address.
    step(1'b1, mk_mtc0(8'h60, 32'hffff_ffff));
    step(1'b1, mk_mfc0(8'h60));
    check("status_mask", rf_wdata, 32'h0000_ff03);
    step(1'b1, mk_mtc0(8'h68, 32'hffff_ffff));
    step(1'b1, mk_mtc0(8'h08, 32'hffff_ffff));
    check("mtc0_no_redirect", exc_valid, 1'b0);
    step(1'b1, mk_mfc0(8'h68));
    check("cause_mask", rf_wdata, 32'h0000_0324);
    step(1'b1, mk_mfc0(8'h08));
    check("unknown_cp0_read", rf_wdata, 32'h0);

    // 4: MTC0 EPC then ERET on the next cycle uses the new EPC.
    step(1'b1, mk_mtc0(8'h70, 32'h44));
    b = '0; b.eret = 1'b1; b.pc = 32'h60;
    step(1'b1, b);
    check("eret_exc_valid", exc_valid, 1'b1);
    check("eret_exc_pc", exc_pc, 32'h44);
    check("eret_cancel", cancel, 1'b1);
    step(1'b1, mk_mfc0(8'h60));
    check("eret_status", rf_wdata, 32'h0000_ff01);

`ifndef CP0_COUNT_EN
    step(1'b1, mk_mfc0(8'h48));
    check("count_absent", rf_wdata, 32'h0);
    step(1'b1, mk_mfc0(8'h58));
    check("compare_absent", rf_wdata, 32'h0);
`endif

    // 5: asynchronous reset mid-cycle, away from any edge.
    step(1'b1, mk_mfc0(8'h60));
    check("pre_reset_hi", HI_data, 32'hA);
    #1;
    resetn = 1'b0;
    #1;
    check("async_reset_hi", HI_data, 32'h0);
    check("async_reset_lo", LO_data, 32'h0);
    check("async_reset_status", rf_wdata, 32'h0);

`ifdef CP0_COUNT_EN
    // 6: timer interrupt. Count counts from reset release; edge k (k even) increments it.
    @(negedge clk);
    resetn = 1'b1;
    apply(1'b1, mk_mtc0(8'h60, 32'h8001));          // commits at edge 1
    step(1'b1, mk_mtc0(8'h58, 32'h4));              // commits at edge 2
    for (int i = 0; i < 6; i++) step(1'b0, '0);     // edges 3..8
    step(1'b1, mk_mfc0(8'h48));
    check("count_after_8", rf_wdata, 32'h4);
    check("no_int_yet", exc_valid, 1'b0);
    b = mk_alu(5'd6, 32'h77); b.pc = 32'h80;
    step(1'b1, b);
    check("int_exc_valid", exc_valid, 1'b1);
    check("int_exc_pc", exc_pc, 32'h0);
    check("int_rf_wen", rf_wen, 1'b0);
    step(1'b1, mk_mfc0(8'h70));
    check("int_epc", rf_wdata, 32'h80);
    step(1'b1, mk_mfc0(8'h68));
    check("int_cause", rf_wdata, 32'h8000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
